// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control unit: FSM states, opcodes,
// datapath FunSel/select codes, the control word layout and field slicers.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_ORR = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_INC = 4'h7;
    localparam logic [3:0] OP_DEC = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_BRA = 4'hA;
    localparam logic [3:0] OP_BEQ = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC;
    localparam logic [3:0] OP_LD  = 4'hD;
    localparam logic [3:0] OP_ST  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Register file: one-hot enables, active high (R1 in bit 0)
    localparam logic [3:0] RF_SEL_NONE = 4'b0000;
    localparam logic [3:0] RF_SEL_R1   = 4'b0001;
    localparam logic [3:0] RF_SEL_R2   = 4'b0010;
    localparam logic [3:0] RF_SEL_R3   = 4'b0100;
    localparam logic [3:0] RF_SEL_R4   = 4'b1000;
    localparam logic [3:0] RF_SEL_ALL  = 4'b1111;

    localparam logic [2:0] RF_OUT_R1 = 3'd0;
    localparam logic [2:0] RF_OUT_R2 = 3'd1;
    localparam logic [2:0] RF_OUT_R3 = 3'd2;
    localparam logic [2:0] RF_OUT_R4 = 3'd3;

    localparam logic [2:0] RF_FUN_DEC   = 3'd0;
    localparam logic [2:0] RF_FUN_INC   = 3'd1;
    localparam logic [2:0] RF_FUN_LOAD  = 3'd2;
    localparam logic [2:0] RF_FUN_CLR   = 3'd3;
    localparam logic [2:0] RF_FUN_LOADL = 3'd4;

    // Address register file
    localparam logic [2:0] ARF_SEL_NONE = 3'b000;
    localparam logic [2:0] ARF_SEL_SP   = 3'b001;
    localparam logic [2:0] ARF_SEL_AR   = 3'b010;
    localparam logic [2:0] ARF_SEL_PC   = 3'b100;
    localparam logic [2:0] ARF_SEL_ALL  = 3'b111;

    localparam logic [1:0] ARF_OUT_PC = 2'd0;
    localparam logic [1:0] ARF_OUT_SP = 2'd1;
    localparam logic [1:0] ARF_OUT_AR = 2'd2;

    localparam logic [1:0] ARF_FUN_DEC   = 2'd0;
    localparam logic [1:0] ARF_FUN_INC   = 2'd1;
    localparam logic [1:0] ARF_FUN_LOADL = 2'd2;
    localparam logic [1:0] ARF_FUN_CLR   = 2'd3;

    localparam logic [1:0] DR_FUN_CLR   = 2'd0;
    localparam logic [1:0] DR_FUN_LOADL = 2'd1;

    // ALU function codes
    localparam logic [4:0] ALU_IDLE   = 5'b00000;
    localparam logic [4:0] ALU_PASS_A = 5'b10000;
    localparam logic [4:0] ALU_ADD    = 5'b10100;
    localparam logic [4:0] ALU_SUB    = 5'b10110;
    localparam logic [4:0] ALU_AND    = 5'b10111;
    localparam logic [4:0] ALU_ORR    = 5'b11000;
    localparam logic [4:0] ALU_XOR    = 5'b11001;

    // Memory strobes (chip select is active low)
    localparam logic MEM_CS_ON   = 1'b0;
    localparam logic MEM_CS_OFF  = 1'b1;
    localparam logic MEM_WR_READ = 1'b0;
    localparam logic MEM_WR_WRITE = 1'b1;

    localparam logic IR_LH_LOW  = 1'b0;
    localparam logic IR_LH_HIGH = 1'b1;

    // Mux selects
    localparam logic [1:0] MUXA_ALU = 2'd0;
    localparam logic [1:0] MUXA_ARF = 2'd1;
    localparam logic [1:0] MUXA_DR  = 2'd2;
    localparam logic [1:0] MUXA_IR  = 2'd3;
    localparam logic [1:0] MUXB_ALU = 2'd0;
    localparam logic [1:0] MUXB_ARF = 2'd1;
    localparam logic [1:0] MUXB_DR  = 2'd2;
    localparam logic [1:0] MUXB_IR  = 2'd3;
    localparam logic [1:0] MUXC_DEF = 2'd0;
    localparam logic       MUXD_RF  = 1'b0;
    localparam logic       MUXD_ARF = 1'b1;

    typedef struct packed {
        logic [3:0] rf_regsel;
        logic [3:0] rf_scrsel;
        logic [2:0] rf_funsel;
        logic [2:0] rf_outasel;
        logic [2:0] rf_outbsel;
        logic       alu_wf;
        logic [4:0] alu_funsel;
        logic [2:0] arf_regsel;
        logic [1:0] arf_funsel;
        logic [1:0] arf_outcsel;
        logic [1:0] arf_outdsel;
        logic       dr_e;
        logic [1:0] dr_funsel;
        logic       mem_wr;
        logic       mem_cs;
        logic       ir_lh;
        logic       ir_write;
        logic [1:0] muxasel;
        logic [1:0] muxbsel;
        logic [1:0] muxcsel;
        logic       muxdsel;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Nothing enabled, memory deselected, every select at zero
    localparam ctrl_t CTRL_IDLE = '{
        rf_regsel:   RF_SEL_NONE,
        rf_scrsel:   RF_SEL_NONE,
        rf_funsel:   RF_FUN_DEC,
        rf_outasel:  RF_OUT_R1,
        rf_outbsel:  RF_OUT_R1,
        alu_wf:      1'b0,
        alu_funsel:  ALU_IDLE,
        arf_regsel:  ARF_SEL_NONE,
        arf_funsel:  ARF_FUN_DEC,
        arf_outcsel: ARF_OUT_PC,
        arf_outdsel: ARF_OUT_PC,
        dr_e:        1'b0,
        dr_funsel:   DR_FUN_CLR,
        mem_wr:      MEM_WR_READ,
        mem_cs:      MEM_CS_OFF,
        ir_lh:       IR_LH_LOW,
        ir_write:    1'b0,
        muxasel:     MUXA_ALU,
        muxbsel:     MUXB_ALU,
        muxcsel:     MUXC_DEF,
        muxdsel:     MUXD_RF
    };

    function automatic logic [3:0] f_op(input logic [15:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [2:0] f_dst(input logic [15:0] ir);
        return ir[11:9];
    endfunction

    function automatic logic [2:0] f_s1(input logic [15:0] ir);
        return ir[8:6];
    endfunction

    function automatic logic [2:0] f_s2(input logic [15:0] ir);
        return ir[5:3];
    endfunction

    function automatic logic [1:0] f_rsel(input logic [15:0] ir);
        return ir[9:8];
    endfunction

    function automatic logic [7:0] f_imm(input logic [15:0] ir);
        return ir[7:0];
    endfunction

    // Two-bit register index -> R1..R4 write enable
    function automatic logic [3:0] rf_sel_of(input logic [1:0] r);
        case (r)
            2'd0:    return RF_SEL_R1;
            2'd1:    return RF_SEL_R2;
            2'd2:    return RF_SEL_R3;
            default: return RF_SEL_R4;
        endcase
    endfunction

    // Two-bit register index -> R1..R4 read-port select
    function automatic logic [2:0] rf_out_of(input logic [1:0] r);
        case (r)
            2'd0:    return RF_OUT_R1;
            2'd1:    return RF_OUT_R2;
            2'd2:    return RF_OUT_R3;
            default: return RF_OUT_R4;
        endcase
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Instruction decoder: turns IR contents and flags into the control words
// used during the execute cycles T2 and T3 (T3 only matters for LD).
module cu_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0]       ir,
    input  logic [3:0]        flags,
    output logic [CTRL_W-1:0] t2_word,
    output logic [CTRL_W-1:0] t3_word
);

    ctrl_t      t2_c;
    ctrl_t      t3_c;
    logic [3:0] op;
    logic [2:0] dst_f;
    logic [2:0] s1_f;
    logic [2:0] s2_f;
    logic [1:0] rsel_f;
    logic       z_flag;
    logic       unused_bits;

    assign op     = f_op(ir);
    assign dst_f  = f_dst(ir);
    assign s1_f   = f_s1(ir);
    assign s2_f   = f_s2(ir);
    assign rsel_f = f_rsel(ir);
    assign z_flag = flags[3];

    // Bit 2 of the register fields is reserved; only Z is consulted
    assign unused_bits = ^{dst_f[2], s1_f[2], s2_f[2], flags[2:0]};

    assign t2_word = t2_c;
    assign t3_word = t3_c;

    // Decode the opcode into the execute-cycle control words
    always_comb begin
        t2_c = CTRL_IDLE;
        t3_c = CTRL_IDLE;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR, OP_MOV: begin
                t2_c.rf_outasel = rf_out_of(s1_f[1:0]);
                t2_c.rf_outbsel = rf_out_of(s2_f[1:0]);
                t2_c.muxdsel    = MUXD_RF;
                t2_c.muxasel    = MUXA_ALU;
                t2_c.rf_regsel  = rf_sel_of(dst_f[1:0]);
                t2_c.rf_funsel  = RF_FUN_LOAD;
                t2_c.alu_wf     = (op != OP_MOV);
                case (op)
                    OP_ADD:  t2_c.alu_funsel = ALU_ADD;
                    OP_SUB:  t2_c.alu_funsel = ALU_SUB;
                    OP_AND:  t2_c.alu_funsel = ALU_AND;
                    OP_ORR:  t2_c.alu_funsel = ALU_ORR;
                    OP_XOR:  t2_c.alu_funsel = ALU_XOR;
                    default: t2_c.alu_funsel = ALU_PASS_A;
                endcase
            end
            OP_INC, OP_DEC: begin
                t2_c.rf_regsel = rf_sel_of(dst_f[1:0]);
                t2_c.rf_funsel = (op == OP_INC) ? RF_FUN_INC : RF_FUN_DEC;
            end
            OP_LDI: begin
                t2_c.muxasel   = MUXA_IR;
                t2_c.rf_regsel = rf_sel_of(rsel_f);
                t2_c.rf_funsel = RF_FUN_LOADL;
            end
            OP_BRA, OP_BEQ, OP_BNE: begin
                // Conditional branches fall back to IDLE when not taken
                if ((op == OP_BRA) || ((op == OP_BEQ) && z_flag) || ((op == OP_BNE) && !z_flag)) begin
                    t2_c.muxbsel    = MUXB_IR;
                    t2_c.arf_regsel = ARF_SEL_PC;
                    t2_c.arf_funsel = ARF_FUN_LOADL;
                end
            end
            OP_LD: begin
                t2_c.arf_outdsel = ARF_OUT_AR;
                t2_c.mem_cs      = MEM_CS_ON;
                t2_c.mem_wr      = MEM_WR_READ;
                t2_c.dr_e        = 1'b1;
                t2_c.dr_funsel   = DR_FUN_LOADL;
                t3_c.muxasel     = MUXA_DR;
                t3_c.rf_regsel   = rf_sel_of(rsel_f);
                t3_c.rf_funsel   = RF_FUN_LOAD;
            end
            OP_ST: begin
                t2_c.rf_outasel  = rf_out_of(rsel_f);
                t2_c.muxdsel     = MUXD_RF;
                t2_c.alu_funsel  = ALU_PASS_A;
                t2_c.arf_outdsel = ARF_OUT_AR;
                t2_c.mem_cs      = MEM_CS_ON;
                t2_c.mem_wr      = MEM_WR_WRITE;
            end
            default: begin
                // NOP and HLT execute as IDLE
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired sequencer for the bring-up datapath: two-byte fetch (T0,T1),
// execute in T2 (plus T3 for LD), one INIT cycle after reset, sticky HALT.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  FlagsOut,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [2:0]  RF_FunSel,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic        ALU_WF,
    output logic [4:0]  ALU_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic [1:0]  ARF_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic        DR_E,
    output logic [1:0]  DR_FunSel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  MuxCSel,
    output logic        MuxDSel,
    output logic [2:0]  T_State,
    output logic        Halted
);

    state_t             state_q;
    state_t             state_d;
    logic [CTRL_W-1:0]  t2_word;
    logic [CTRL_W-1:0]  t3_word;
    ctrl_t              ctrl;
    logic [3:0]         op;

    assign op = f_op(IROut);

    cu_decoder u_decoder (
        .ir      (IROut),
        .flags   (FlagsOut),
        .t2_word (t2_word),
        .t3_word (t3_word)
    );

    // State register; reset forces INIT immediately
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; only LD and HLT change the T2 successor
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2: begin
                if (op == OP_LD) begin
                    state_d = ST_T3;
                end else if (op == OP_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T3:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_INIT;
        endcase
    end

    // Control word per state; forced IDLE while reset is held low
    always_comb begin
        ctrl = CTRL_IDLE;
        if (Reset) begin
            case (state_q)
                ST_INIT: begin
                    ctrl.rf_regsel  = RF_SEL_ALL;
                    ctrl.rf_scrsel  = RF_SEL_ALL;
                    ctrl.rf_funsel  = RF_FUN_CLR;
                    ctrl.arf_regsel = ARF_SEL_ALL;
                    ctrl.arf_funsel = ARF_FUN_CLR;
                end
                ST_T0, ST_T1: begin
                    ctrl.arf_outdsel = ARF_OUT_PC;
                    ctrl.mem_cs      = MEM_CS_ON;
                    ctrl.mem_wr      = MEM_WR_READ;
                    ctrl.ir_lh       = (state_q == ST_T1) ? IR_LH_HIGH : IR_LH_LOW;
                    ctrl.ir_write    = 1'b1;
                    ctrl.arf_regsel  = ARF_SEL_PC;
                    ctrl.arf_funsel  = ARF_FUN_INC;
                end
                ST_T2:   ctrl = ctrl_t'(t2_word);
                ST_T3:   ctrl = ctrl_t'(t3_word);
                default: ctrl = CTRL_IDLE;
            endcase
        end
    end

    assign RF_RegSel   = ctrl.rf_regsel;
    assign RF_ScrSel   = ctrl.rf_scrsel;
    assign RF_FunSel   = ctrl.rf_funsel;
    assign RF_OutASel  = ctrl.rf_outasel;
    assign RF_OutBSel  = ctrl.rf_outbsel;
    assign ALU_WF      = ctrl.alu_wf;
    assign ALU_FunSel  = ctrl.alu_funsel;
    assign ARF_RegSel  = ctrl.arf_regsel;
    assign ARF_FunSel  = ctrl.arf_funsel;
    assign ARF_OutCSel = ctrl.arf_outcsel;
    assign ARF_OutDSel = ctrl.arf_outdsel;
    assign DR_E        = ctrl.dr_e;
    assign DR_FunSel   = ctrl.dr_funsel;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_Write    = ctrl.ir_write;
    assign MuxASel     = ctrl.muxasel;
    assign MuxBSel     = ctrl.muxbsel;
    assign MuxCSel     = ctrl.muxcsel;
    assign MuxDSel     = ctrl.muxdsel;
    assign T_State     = state_q;
    assign Halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
`timescale 1ns/1ps
module tb_cpu_control_unit;
    import cpu_ctrl_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  FlagsOut;
    logic [3:0]  RF_RegSel;
    logic [3:0]  RF_ScrSel;
    logic [2:0]  RF_FunSel;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic        ALU_WF;
    logic [4:0]  ALU_FunSel;
    logic [2:0]  ARF_RegSel;
    logic [1:0]  ARF_FunSel;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic        DR_E;
    logic [1:0]  DR_FunSel;
    logic        Mem_WR;
    logic        Mem_CS;
    logic        IR_LH;
    logic        IR_Write;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic [1:0]  MuxCSel;
    logic        MuxDSel;
    logic [2:0]  T_State;
    logic        Halted;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_t0 = 0;

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    cpu_control_unit dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IROut       (IROut),
        .FlagsOut    (FlagsOut),
        .RF_RegSel   (RF_RegSel),
        .RF_ScrSel   (RF_ScrSel),
        .RF_FunSel   (RF_FunSel),
        .RF_OutASel  (RF_OutASel),
        .RF_OutBSel  (RF_OutBSel),
        .ALU_WF      (ALU_WF),
        .ALU_FunSel  (ALU_FunSel),
        .ARF_RegSel  (ARF_RegSel),
        .ARF_FunSel  (ARF_FunSel),
        .ARF_OutCSel (ARF_OutCSel),
        .ARF_OutDSel (ARF_OutDSel),
        .DR_E        (DR_E),
        .DR_FunSel   (DR_FunSel),
        .Mem_WR      (Mem_WR),
        .Mem_CS      (Mem_CS),
        .IR_LH       (IR_LH),
        .IR_Write    (IR_Write),
        .MuxASel     (MuxASel),
        .MuxBSel     (MuxBSel),
        .MuxCSel     (MuxCSel),
        .MuxDSel     (MuxDSel),
        .T_State     (T_State),
        .Halted      (Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".rf_regsel"},  RF_RegSel,  4'b0000);
        chk({tag, ".rf_scrsel"},  RF_ScrSel,  4'b0000);
        chk({tag, ".arf_regsel"}, ARF_RegSel, 3'b000);
        chk({tag, ".ir_write"},   IR_Write,   1'b0);
        chk({tag, ".dr_e"},       DR_E,       1'b0);
        chk({tag, ".mem_cs"},     Mem_CS,     1'b1);
        chk({tag, ".mem_wr"},     Mem_WR,     1'b0);
        chk({tag, ".alu_wf"},     ALU_WF,     1'b0);
        chk({tag, ".muxa"},       MuxASel,    2'd0);
        chk({tag, ".muxb"},       MuxBSel,    2'd0);
    endtask

    task automatic check_init(input string tag);
        chk({tag, ".state"},      T_State,    S_INIT);
        chk({tag, ".rf_regsel"},  RF_RegSel,  4'b1111);
        chk({tag, ".rf_scrsel"},  RF_ScrSel,  4'b1111);
        chk({tag, ".rf_funsel"},  RF_FunSel,  RF_FUN_CLR);
        chk({tag, ".arf_regsel"}, ARF_RegSel, ARF_SEL_ALL);
        chk({tag, ".arf_funsel"}, ARF_FunSel, ARF_FUN_CLR);
        chk({tag, ".ir_write"},   IR_Write,   1'b0);
    endtask

    task automatic run_fetch(input logic [15:0] instr, input logic [3:0] fl, input int prev_len);
        chk("t0.state",      T_State,     S_T0);
        if (prev_len != 0) begin
            chk("t0.prev_len", cyc - last_t0, prev_len);
        end
        last_t0 = cyc;
        chk("t0.ir_write",   IR_Write,    1'b1);
        chk("t0.ir_lh",      IR_LH,       1'b0);
        chk("t0.mem_cs",     Mem_CS,      1'b0);
        chk("t0.mem_wr",     Mem_WR,      1'b0);
        chk("t0.outd",       ARF_OutDSel, ARF_OUT_PC);
        chk("t0.arf_regsel", ARF_RegSel,  ARF_SEL_PC);
        chk("t0.arf_funsel", ARF_FunSel,  ARF_FUN_INC);
        chk("t0.rf_regsel",  RF_RegSel,   4'b0000);
        step();
        chk("t1.state",      T_State,     S_T1);
        chk("t1.ir_lh",      IR_LH,       1'b1);
        chk("t1.ir_write",   IR_Write,    1'b1);
        chk("t1.arf_regsel", ARF_RegSel,  ARF_SEL_PC);
        IROut    = instr;
        FlagsOut = fl;
        step();
        chk("t2.state",      T_State,     S_T2);
        $display("instr %04h flags %04b executing at cycle %0d", instr, fl, cyc);
    endtask

    initial begin
        Reset    = 1'b0;
        IROut    = 16'h0000;
        FlagsOut = 4'b0000;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst.state", T_State, S_INIT);
            check_idle("rst");
            step();
        end
        Reset = 1'b1;
        #1;
        check_init("init");
        step();

        run_fetch(16'h1298, 4'b0000, 0);
        chk("add.outa",   RF_OutASel, RF_OUT_R3);
        chk("add.outb",   RF_OutBSel, RF_OUT_R4);
        chk("add.alu",    ALU_FunSel, ALU_ADD);
        chk("add.wf",     ALU_WF,     1'b1);
        chk("add.muxa",   MuxASel,    MUXA_ALU);
        chk("add.muxd",   MuxDSel,    MUXD_RF);
        chk("add.regsel", RF_RegSel,  4'b0010);
        chk("add.funsel", RF_FunSel,  RF_FUN_LOAD);
        step();

        run_fetch(16'hB042, 4'b1000, 3);
        chk("beq1.muxb",   MuxBSel,    MUXB_IR);
        chk("beq1.arfsel", ARF_RegSel, ARF_SEL_PC);
        chk("beq1.arffun", ARF_FunSel, ARF_FUN_LOADL);
        FlagsOut = 4'b0000;
        #1;
        chk("beq1z0.arfsel", ARF_RegSel, 3'b000);
        step();

        run_fetch(16'hB042, 4'b0000, 3);
        check_idle("beq0");
        step();

        run_fetch(16'hC042, 4'b0000, 3);
        chk("bne.muxb",   MuxBSel,    MUXB_IR);
        chk("bne.arfsel", ARF_RegSel, ARF_SEL_PC);
        chk("bne.arffun", ARF_FunSel, ARF_FUN_LOADL);
        step();

        run_fetch(16'h7400, 4'b0000, 3);
        chk("inc.regsel", RF_RegSel, 4'b0100);
        chk("inc.funsel", RF_FunSel, RF_FUN_INC);
        chk("inc.wf",     ALU_WF,    1'b0);
        step();

        run_fetch(16'h93AB, 4'b0000, 3);
        chk("ldi.muxa",   MuxASel,   MUXA_IR);
        chk("ldi.regsel", RF_RegSel, 4'b1000);
        chk("ldi.funsel", RF_FunSel, RF_FUN_LOADL);
        step();

        run_fetch(16'hD100, 4'b0000, 3);
        chk("ld2.outd",   ARF_OutDSel, ARF_OUT_AR);
        chk("ld2.dr_e",   DR_E,        1'b1);
        chk("ld2.drfun",  DR_FunSel,   DR_FUN_LOADL);
        chk("ld2.mem_cs", Mem_CS,      1'b0);
        chk("ld2.mem_wr", Mem_WR,      1'b0);
        chk("ld2.regsel", RF_RegSel,   4'b0000);
        step();
        chk("ld3.state",  T_State,   S_T3);
        chk("ld3.muxa",   MuxASel,   MUXA_DR);
        chk("ld3.regsel", RF_RegSel, 4'b0010);
        chk("ld3.funsel", RF_FunSel, RF_FUN_LOAD);
        chk("ld3.dr_e",   DR_E,      1'b0);
        step();

        run_fetch(16'hE200, 4'b0000, 4);
        chk("st.mem_cs", Mem_CS,      1'b0);
        chk("st.mem_wr", Mem_WR,      1'b1);
        chk("st.outd",   ARF_OutDSel, ARF_OUT_AR);
        chk("st.outa",   RF_OutASel,  RF_OUT_R3);
        chk("st.alu",    ALU_FunSel,  ALU_PASS_A);
        chk("st.muxd",   MuxDSel,     MUXD_RF);
        chk("st.regsel", RF_RegSel,   4'b0000);
        step();

        run_fetch(16'hF000, 4'b0000, 3);
        check_idle("hlt.t2");
        chk("hlt.t2.halted", Halted, 1'b0);
        step();
        for (int i = 0; i < 22; i++) begin
            chk("halt.state",  T_State, S_HALT);
            chk("halt.halted", Halted,  1'b1);
            check_idle("halt");
            IROut    = 16'($urandom);
            FlagsOut = 4'($urandom);
            #1;
            check_idle("halt.newir");
            step();
        end

        Reset = 1'b0;
        #1;
        chk("hrst.state",  T_State, S_INIT);
        chk("hrst.halted", Halted,  1'b0);
        check_idle("hrst");
        step();
        Reset = 1'b1;
        #1;
        check_init("hrst.init");
        step();
        chk("hrst.t0", T_State, S_T0);
        step();
        chk("mid.t1",    T_State, S_T1);
        chk("mid.ir_lh", IR_LH,   1'b1);

        Reset = 1'b0;
        #1;
        chk("mid.state", T_State, S_INIT);
        check_idle("mid");
        step();
        Reset = 1'b1;
        #1;
        check_init("mid.init");
        step();
        chk("mid.t0",      T_State,  S_T0);
        chk("mid.t0.irwr", IR_Write, 1'b1);
        $display("reset pulse recovered at cycle %0d", cyc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
